// File: rtl/draw_cmd_sched.sv
// Draw command scheduler: two requester FIFOs, round-robin pop, one command
// in flight to the placer at a time with ack timeout and completion pulse.
module draw_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          wr;

  // full is from the registered count, so a same-cycle pop never frees a slot
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign drop  = push && full;
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
endmodule

module draw_cmd_sched #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push0,
  input  logic [1:0] op0,
  input  logic [5:0] indx0,
  input  logic [9:0] x0,
  input  logic [8:0] y0,
  input  logic       push1,
  input  logic [1:0] op1,
  input  logic [5:0] indx1,
  input  logic [9:0] x1,
  input  logic [8:0] y1,
  output logic       full0,
  output logic       full1,
  input  logic       plc_busy,
  output logic       add_img,
  output logic       rem_img,
  output logic       add_fnt,
  output logic [4:0] image_indx,
  output logic [5:0] fnt_indx,
  output logic [9:0] xloc,
  output logic [8:0] yloc,
  output logic       done,
  output logic       done_port,
  output logic [1:0] ovf,
  output logic       cmd_err,
  output logic       to_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  logic [1:0]       push_v, pop_v, empty_v, full_v, drop_v;
  logic [1:0][26:0] wdata_v, rdata_v;
  state_t           state;
  logic             last_grant, grant, win, do_pop, c_ok;
  logic [1:0]       ack_cnt;
  logic [5:0]       indx_r;
  logic [26:0]      cmd;
  logic [1:0]       c_op;
  logic [5:0]       c_indx;
  logic [9:0]       c_x;
  logic [8:0]       c_y;

  assign push_v     = {push1, push0};
  assign wdata_v[0] = {op0, indx0, x0, y0};
  assign wdata_v[1] = {op1, indx1, x1, y1};
  assign full0      = full_v[0];
  assign full1      = full_v[1];

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    draw_cmd_fifo #(.DEPTH(DEPTH), .W(27)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_v[p]),
      .wdata (wdata_v[p]),
      .pop   (pop_v[p]),
      .rdata (rdata_v[p]),
      .empty (empty_v[p]),
      .full  (full_v[p]),
      .drop  (drop_v[p])
    );
  end

  // on a tie the port that did not win last time goes next
  always_comb begin
    win = last_grant;
    if (!empty_v[0] && !empty_v[1]) win = ~last_grant;
    else if (!empty_v[0])           win = 1'b0;
    else if (!empty_v[1])           win = 1'b1;
  end

  assign do_pop = (state == IDLE) && !plc_busy && (empty_v != 2'b11);
  assign pop_v  = do_pop ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign cmd    = rdata_v[win];
  assign c_op   = cmd[26:25];
  assign c_indx = cmd[24:19];
  assign c_x    = cmd[18:9];
  assign c_y    = cmd[8:0];
  assign c_ok   = (c_op != 2'd3) && !(c_op == 2'd2 && c_indx > 6'd41) &&
                  (c_x <= 10'd639) && (c_y <= 9'd479);

  assign image_indx = indx_r[4:0];
  assign fnt_indx   = indx_r;

  // the pulse is registered at the pop edge so it lands in the ISSUE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      add_img    <= 1'b0;
      rem_img    <= 1'b0;
      add_fnt    <= 1'b0;
      done       <= 1'b0;
      done_port  <= 1'b0;
      indx_r     <= '0;
      xloc       <= '0;
      yloc       <= '0;
      ovf        <= '0;
      cmd_err    <= 1'b0;
      to_err     <= 1'b0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      ack_cnt    <= '0;
    end else begin
      add_img <= 1'b0;
      rem_img <= 1'b0;
      add_fnt <= 1'b0;
      done    <= 1'b0;
      ovf     <= ovf | drop_v;
      case (state)
        IDLE: if (do_pop) begin
          last_grant <= win;
          grant      <= win;
          indx_r     <= c_indx;
          xloc       <= c_x;
          yloc       <= c_y;
          if (c_ok) begin
            state   <= ISSUE;
            add_img <= (c_op == 2'd0);
            rem_img <= (c_op == 2'd1);
            add_fnt <= (c_op == 2'd2);
          end else begin
            cmd_err <= 1'b1;
          end
        end
        ISSUE: begin
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: if (plc_busy) begin
          state <= WAIT_DONE;
        end else begin
          ack_cnt <= ack_cnt + 2'd1;
          if (ack_cnt == 2'd2) begin
            to_err    <= 1'b1;
            done      <= 1'b1;
            done_port <= grant;
            state     <= IDLE;
          end
        end
        WAIT_DONE: if (!plc_busy) begin
          done      <= 1'b1;
          done_port <= grant;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
